// File: rtl/mem2_wb_if.sv
// Bundle between the mem1 stage (master) and the mem2/writeback stage (slave):
// mem1 result fields in, register-file write and commit/exception fields out.
interface mem2_wb_if #(
  parameter int EXP_W = 7,
  parameter int PC_W  = 32
);
  logic             flush;
  logic             stall_by_cache;
  logic             mem_en_in;
  logic             inst_valid_in;
  logic [4:0]       mem_rd_in;
  logic [31:0]      mem_data_in;
  logic [EXP_W-1:0] mem_exp_in;
  logic [31:0]      cache_badv_in;
  logic [1:0]       addr_lo_in;
  logic [1:0]       width_in;
  logic             signed_ext_in;
  logic [PC_W-1:0]  pc_in;

  logic             wb_valid;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [EXP_W-1:0] wb_exp;
  logic [31:0]      wb_badv;
  logic [PC_W-1:0]  wb_pc;
  logic             exc_hold;

  modport master (
    output flush, stall_by_cache, mem_en_in, inst_valid_in, mem_rd_in,
           mem_data_in, mem_exp_in, cache_badv_in, addr_lo_in, width_in,
           signed_ext_in, pc_in,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_exp, wb_badv, wb_pc, exc_hold
  );

  modport slave (
    input  flush, stall_by_cache, mem_en_in, inst_valid_in, mem_rd_in,
           mem_data_in, mem_exp_in, cache_badv_in, addr_lo_in, width_in,
           signed_ext_in, pc_in,
    output wb_valid, wb_we, wb_rd, wb_data, wb_exp, wb_badv, wb_pc, exc_hold
  );
endinterface

// File: rtl/mem2_wb.sv
// mem2/writeback stage: registers the mem1 result, aligns and extends loads,
// and holds off younger instructions after a faulting op until a flush.
module mem2_wb #(
  parameter int EXP_W = 7,
  parameter int PC_W  = 32
) (
  input  logic        clk,
  input  logic        rstn,
  mem2_wb_if.slave    bus
);

  // Handshake: an instruction is taken when inst_valid_in is high, the cache
  // is not stalling, no flush is asserted and the stage is in RUN; any other
  // cycle produces a bubble (wb_valid/wb_we/wb_exp low).
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, next_state;
  logic   accept;
  logic   has_exp;

  logic [31:0]      shifted;
  logic [31:0]      load_data;

  logic             valid_q;
  logic             we_q;
  logic [4:0]       rd_q;
  logic [31:0]      data_q;
  logic [EXP_W-1:0] exp_q;
  logic [31:0]      badv_q;
  logic [PC_W-1:0]  pc_q;

  assign has_exp = (bus.mem_exp_in != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= next_state;
  end

  // flush wins over everything, including a faulting input in the same cycle
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      RUN: begin
        if (!bus.flush && bus.inst_valid_in && !bus.stall_by_cache) begin
          accept = 1'b1;
          if (has_exp) next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.flush) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Halfword accesses arrive with addr_lo_in[0] == 0, so the shift never
  // splits the halfword across the word boundary.
  always_comb begin
    shifted   = bus.mem_data_in >> {bus.addr_lo_in, 3'b000};
    load_data = bus.mem_data_in;
    if (bus.mem_en_in) begin
      case (bus.width_in)
        2'd0:    load_data = {{24{bus.signed_ext_in & shifted[7]}},  shifted[7:0]};
        2'd1:    load_data = {{16{bus.signed_ext_in & shifted[15]}}, shifted[15:0]};
        default: load_data = bus.mem_data_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      exp_q   <= '0;
      badv_q  <= '0;
      pc_q    <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      we_q    <= (bus.mem_rd_in != 5'd0) && !has_exp;
      rd_q    <= bus.mem_rd_in;
      data_q  <= load_data;
      exp_q   <= bus.mem_exp_in;
      badv_q  <= has_exp ? bus.cache_badv_in : 32'd0;
      pc_q    <= bus.pc_in;
    end else begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      exp_q   <= '0;
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_rd    = rd_q;
  assign bus.wb_data  = data_q;
  assign bus.wb_exp   = exp_q;
  assign bus.wb_badv  = badv_q;
  assign bus.wb_pc    = pc_q;
  assign bus.exc_hold = (state == HOLD);

endmodule

// File: tb/tb_mem2_wb.sv
// Bench for mem2_wb: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the stage's rules.
module tb_mem2_wb;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  logic [31:0] pc_ctr;

  mem2_wb_if #(.EXP_W(7), .PC_W(32)) bus ();

  mem2_wb #(.EXP_W(7), .PC_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_hold;
  logic        m_valid, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_badv, m_pc;
  logic [6:0]  m_exp;

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] w, input logic s, input logic en);
    logic [31:0] v;
    if (!en) return d;
    v = d / (32'd1 << (8 * a));
    if (w == 2'd0) begin
      v = v % 256;
      if (s && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = v % 65536;
      if (s && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_valid = 0; m_we = 0; m_rd = 0;
    m_data = 0; m_badv = 0; m_pc = 0; m_exp = 0;
  endtask

  task automatic model_step();
    bit taken;
    taken = bus.inst_valid_in && !bus.stall_by_cache && !bus.flush && !m_hold;
    if (taken) begin
      m_valid = 1;
      m_we    = (bus.mem_rd_in != 0) && (bus.mem_exp_in == 0);
      m_rd    = bus.mem_rd_in;
      m_data  = ref_load(bus.mem_data_in, bus.addr_lo_in, bus.width_in,
                         bus.signed_ext_in, bus.mem_en_in);
      m_exp   = bus.mem_exp_in;
      m_badv  = (bus.mem_exp_in != 0) ? bus.cache_badv_in : 32'd0;
      m_pc    = bus.pc_in;
      if (bus.mem_exp_in != 0) m_hold = 1;
    end else begin
      m_valid = 0; m_we = 0; m_exp = 0;
      if (bus.flush) m_hold = 0;
    end
  endtask

  // driver tasks
  task automatic set_in(input logic v, input logic en, input logic [4:0] rd,
                        input logic [31:0] d, input logic [6:0] e, input logic [31:0] badv,
                        input logic [1:0] alo, input logic [1:0] w, input logic s);
    bus.inst_valid_in = v;   bus.mem_en_in   = en;  bus.mem_rd_in     = rd;
    bus.mem_data_in   = d;   bus.mem_exp_in  = e;   bus.cache_badv_in = badv;
    bus.addr_lo_in    = alo; bus.width_in    = w;   bus.signed_ext_in = s;
    pc_ctr            = pc_ctr + 4;
    bus.pc_in         = pc_ctr;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 0; bus.stall_by_cache = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rstn = 0; pc_ctr = 0; idle_in(); model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.wb_valid); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", bus.wb_we); end
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %h exp 0", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.wb_data); end
    checks++; if (bus.wb_exp !== 7'd0) begin errors++; $display("FAIL reset_exp got %h exp 0", bus.wb_exp); end
    checks++; if (bus.wb_badv !== 32'd0) begin errors++; $display("FAIL reset_badv got %h exp 0", bus.wb_badv); end
    checks++; if (bus.wb_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.wb_pc); end
    checks++; if (bus.exc_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %0b exp 0", bus.exc_hold); end
    @(negedge clk); rstn = 1;
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %0b exp 0", bus.wb_valid); end
  endtask

  task automatic test_load_align();
    set_in(1, 1, 5, 32'h80FF_7F01, 0, 0, 3, 0, 1); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd5)
      begin errors++; $display("FAIL lb_ctrl got v%0b we%0b rd%0d exp v1 we1 rd5", bus.wb_valid, bus.wb_we, bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", bus.wb_data); end
    set_in(1, 1, 6, 32'h80FF_7F01, 0, 0, 2, 1, 0); tick();
    checks++; if (bus.wb_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu got %h exp 000080ff", bus.wb_data); end
    set_in(1, 1, 6, 32'h80FF_7F01, 0, 0, 2, 1, 1); tick();
    checks++; if (bus.wb_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_signed got %h exp ffff80ff", bus.wb_data); end
    set_in(1, 1, 6, 32'h80FF_7F01, 0, 0, 1, 0, 0); tick();
    checks++; if (bus.wb_data !== 32'h0000_007F) begin errors++; $display("FAIL lbu_off1 got %h exp 0000007f", bus.wb_data); end
    set_in(1, 1, 6, 32'h80FF_7F01, 0, 0, 0, 2, 1); tick();
    checks++; if (bus.wb_data !== 32'h80FF_7F01) begin errors++; $display("FAIL lw got %h exp 80ff7f01", bus.wb_data); end
    idle_in(); tick();
  endtask

  task automatic test_stall();
    set_in(1, 1, 7, 32'h0000_0042, 0, 0, 0, 2, 0);
    bus.stall_by_cache = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble%0d got %0b exp 0", i, bus.wb_valid); end
    end
    bus.stall_by_cache = 0; tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7)
      begin errors++; $display("FAIL stall_release got v%0b rd%0d exp v1 rd7", bus.wb_valid, bus.wb_rd); end
    idle_in(); tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL stall_once got %0b exp 0", bus.wb_valid); end
  endtask

  task automatic test_rd_zero();
    set_in(1, 0, 0, 32'h0000_1234, 0, 0, 3, 0, 1); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL rd0 got v%0b we%0b exp v1 we0", bus.wb_valid, bus.wb_we); end
    checks++; if (bus.wb_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got %h exp 00001234", bus.wb_data); end
    idle_in(); tick();
  endtask

  task automatic test_exc_hold();
    set_in(1, 1, 3, 32'h1111_1111, 7'h04, 32'hDEAD_BEE0, 0, 2, 0); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0 || bus.wb_exp !== 7'h04)
      begin errors++; $display("FAIL fault_out got v%0b we%0b exp%h exp v1 we0 exp04", bus.wb_valid, bus.wb_we, bus.wb_exp); end
    checks++; if (bus.wb_badv !== 32'hDEAD_BEE0) begin errors++; $display("FAIL fault_badv got %h exp deadbee0", bus.wb_badv); end
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 5'(i + 10), 32'(i), 0, 0, 0, 2, 0); tick();
      checks++; if (bus.wb_valid !== 1'b0 || bus.exc_hold !== 1'b1)
        begin errors++; $display("FAIL hold%0d got v%0b h%0b exp v0 h1", i, bus.wb_valid, bus.exc_hold); end
    end
    bus.flush = 1; tick();
    checks++; if (bus.exc_hold !== 1'b0 || bus.wb_valid !== 1'b0)
      begin errors++; $display("FAIL flush_release got h%0b v%0b exp h0 v0", bus.exc_hold, bus.wb_valid); end
    bus.flush = 0;
    set_in(1, 0, 9, 32'hCAFE_0009, 0, 0, 0, 2, 0); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd9)
      begin errors++; $display("FAIL after_flush got v%0b we%0b rd%0d exp v1 we1 rd9", bus.wb_valid, bus.wb_we, bus.wb_rd); end
    // flush alongside a faulting input: dropped, stays in RUN
    set_in(1, 1, 4, 32'h0, 7'h01, 32'h0000_0BAD, 0, 2, 0); bus.flush = 1; tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.exc_hold !== 1'b0)
      begin errors++; $display("FAIL flush_fault got v%0b h%0b exp v0 h0", bus.wb_valid, bus.exc_hold); end
    bus.flush = 0;
    set_in(1, 0, 2, 32'h0000_0002, 0, 0, 0, 2, 0); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd2)
      begin errors++; $display("FAIL post_flush_fault got v%0b rd%0d exp v1 rd2", bus.wb_valid, bus.wb_rd); end
    idle_in(); tick();
  endtask

  task automatic test_reset_mid_hold();
    set_in(1, 1, 8, 32'h5555_5555, 7'h10, 32'h1234_5670, 0, 2, 0); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.exc_hold !== 1'b1)
      begin errors++; $display("FAIL pre_reset got v%0b h%0b exp v1 h1", bus.wb_valid, bus.exc_hold); end
    #2 rstn = 0;
    #1;
    model_reset();
    checks++; if ({bus.wb_valid, bus.wb_we, bus.wb_exp, bus.exc_hold} !== 10'd0 ||
                  bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0 || bus.wb_badv !== 32'd0 || bus.wb_pc !== 32'd0)
      begin errors++; $display("FAIL async_reset got v%0b h%0b data%h badv%h exp all 0", bus.wb_valid, bus.exc_hold, bus.wb_data, bus.wb_badv); end
    idle_in();
    @(posedge clk); @(negedge clk); rstn = 1;
    set_in(1, 0, 1, 32'h0000_00AA, 0, 0, 0, 2, 0); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_00AA || bus.exc_hold !== 1'b0)
      begin errors++; $display("FAIL after_reset got v%0b d%h h%0b exp v1 d000000aa h0", bus.wb_valid, bus.wb_data, bus.exc_hold); end
    idle_in(); tick();
  endtask

  task automatic test_random();
    logic [1:0] w, alo;
    for (int n = 0; n < 400; n++) begin
      w   = 2'($urandom_range(0, 3));
      alo = 2'($urandom_range(0, 3));
      if (w == 2'd1) alo[0] = 1'b0;
      set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom, ($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'd0,
             $urandom, alo, w, 1'($urandom_range(0, 1)));
      bus.stall_by_cache = ($urandom_range(0, 4) == 0);
      bus.flush          = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (bus.wb_valid !== m_valid || bus.wb_we !== m_we || bus.wb_exp !== m_exp || bus.exc_hold !== m_hold) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got v%0b we%0b exp%h h%0b exp v%0b we%0b exp%h h%0b", n,
                 bus.wb_valid, bus.wb_we, bus.wb_exp, bus.exc_hold, m_valid, m_we, m_exp, m_hold);
      end
      if (m_valid) begin
        checks++;
        if (bus.wb_rd !== m_rd || bus.wb_data !== m_data || bus.wb_badv !== m_badv || bus.wb_pc !== m_pc) begin
          errors++;
          $display("FAIL rand_data[%0d] got rd%0d d%h b%h pc%h exp rd%0d d%h b%h pc%h", n,
                   bus.wb_rd, bus.wb_data, bus.wb_badv, bus.wb_pc, m_rd, m_data, m_badv, m_pc);
        end
      end
    end
    idle_in(); tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_align();
    test_stall();
    test_rd_zero();
    test_exc_hold();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
